// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: opcode encodings and FSM state type shared by alu_mc and alu_mc_comb.
package alu_mc_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_AND = 3'b010;
  localparam logic [OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [OP_W-1:0] OP_MUL = 3'b100;
  localparam logic [OP_W-1:0] OP_SLT = 3'b101;
  localparam logic [OP_W-1:0] OP_XOR = 3'b110;
  localparam logic [OP_W-1:0] OP_ILL = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_mc_comb.sv
// alu_mc_comb: single-cycle combinational op unit (ADD/SUB/AND/OR/XOR/SLT/illegal).
// MUL is not handled here; it yields zero and is resolved by the caller.
// Ports:
//   a_i, b_i     operands
//   op_i         3-bit opcode
//   result_c_o   combinational result
//   ovf_c_o      signed ADD/SUB overflow, 0 otherwise
//   illegal_c_o  opcode 111
module alu_mc_comb
  import alu_mc_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [OP_W-1:0]  op_i,
  output logic [WIDTH-1:0] result_c_o,
  output logic             ovf_c_o,
  output logic             illegal_c_o
);

  logic [WIDTH-1:0] sum_c;
  logic [WIDTH-1:0] diff_c;

  assign sum_c  = a_i + b_i;
  assign diff_c = a_i - b_i;

  // Opcode decode
  always_comb begin
    result_c_o  = '0;
    ovf_c_o     = 1'b0;
    illegal_c_o = 1'b0;
    case (op_i)
      OP_ADD: begin
        result_c_o = sum_c;
        ovf_c_o    = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum_c[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SUB: begin
        result_c_o = diff_c;
        ovf_c_o    = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff_c[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_AND: result_c_o = a_i & b_i;
      OP_OR:  result_c_o = a_i | b_i;
      OP_XOR: result_c_o = a_i ^ b_i;
      OP_SLT: result_c_o[0] = $signed(a_i) < $signed(b_i);
      OP_ILL: illegal_c_o = 1'b1;
      default: result_c_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle handshaked ALU. Single-cycle ops finish on the accept edge;
// unsigned MUL runs as a WIDTH-step shift-add. One operation in flight.
// Optional macro ALU_MC_STICKY_OVF_EN adds ovf_clr / ovf_sticky.
// Ports:
//   clk, rst              clock, async active-high reset
//   in_valid / in_ready   request handshake
//   a, b, alu_control     operands and opcode
//   out_valid / out_ready result handshake
//   result, zero, overflow, illegal  registered result flags
//   ovf_clr, ovf_sticky   (macro only) sticky overflow clear / flag
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  alu_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
`ifdef ALU_MC_STICKY_OVF_EN
  input  logic             ovf_clr,
  output logic             ovf_sticky,
`endif
  output logic             illegal
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned ACC_W = 2 * WIDTH;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;
  logic               illegal_q, illegal_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;

  logic [WIDTH-1:0]   comb_res_c;
  logic               comb_ovf_c;
  logic               comb_ill_c;
  logic [ACC_W-1:0]   acc_sum_c;

  alu_mc_comb #(.WIDTH(WIDTH)) u_comb (
    .a_i         (a),
    .b_i         (b),
    .op_i        (alu_control),
    .result_c_o  (comb_res_c),
    .ovf_c_o     (comb_ovf_c),
    .illegal_c_o (comb_ill_c)
  );

  // Partial product including the current multiplier bit
  assign acc_sum_c = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    result_d    = result_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    illegal_d   = illegal_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          in_ready_d = 1'b0;
          if (alu_control == OP_MUL) begin
            state_d  = ST_MUL;
            cnt_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
          end else begin
            state_d     = ST_DONE;
            result_d    = comb_res_c;
            zero_d      = (comb_res_c == '0);
            ovf_d       = comb_ovf_c;
            illegal_d   = comb_ill_c;
            out_valid_d = 1'b1;
          end
        end
      end
      ST_MUL: begin
        acc_d    = acc_sum_c;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d     = ST_DONE;
          result_d    = acc_sum_c[WIDTH-1:0];
          zero_d      = (acc_sum_c[WIDTH-1:0] == '0);
          ovf_d       = |acc_sum_c[ACC_W-1:WIDTH];
          illegal_d   = 1'b0;
          out_valid_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      ovf_q       <= 1'b0;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      illegal_q   <= illegal_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;
  assign illegal   = illegal_q;

`ifdef ALU_MC_STICKY_OVF_EN
  logic sticky_q, sticky_d;

  // Set on an overflowing result handshake; set beats clear
  always_comb begin
    sticky_d = sticky_q;
    if (ovf_clr) sticky_d = 1'b0;
    if (out_valid_q && out_ready && ovf_q) sticky_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sticky_q <= 1'b0;
    else     sticky_q <= sticky_d;
  end

  assign ovf_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [2:0]    alu_control;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          zero;
  logic          overflow;
  logic          illegal;
`ifdef ALU_MC_STICKY_OVF_EN
  logic          ovf_clr;
  logic          ovf_sticky;
`endif

  typedef struct {
    logic [W-1:0] res;
    logic         zero;
    logic         ovf;
    logic         ill;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  alu_mc #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .alu_control (alu_control),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .overflow    (overflow),
`ifdef ALU_MC_STICKY_OVF_EN
    .ovf_clr     (ovf_clr),
    .ovf_sticky  (ovf_sticky),
`endif
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  // Reference model built from wide signed/unsigned arithmetic
  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    longint signed sx, sy, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e.res = '0; e.ovf = 1'b0; e.ill = 1'b0;
    case (op)
      3'b000: begin r = sx + sy; e.res = x + y; e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      3'b001: begin r = sx - sy; e.res = x - y; e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      3'b010: e.res = x & y;
      3'b011: e.res = x | y;
      3'b100: begin p = {32'd0, x} * {32'd0, y}; e.res = p[31:0]; e.ovf = |p[63:32]; end
      3'b101: e.res = (sx < sy) ? 32'd1 : 32'd0;
      3'b110: e.res = x ^ y;
      default: e.ill = 1'b1;
    endcase
    e.zero = (e.res == '0);
    return e;
  endfunction

  // Present an op, wait (bounded) for acceptance, record expectation
  task automatic send(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    int n;
    @(negedge clk);
    in_valid = 1'b1; alu_control = op; a = x; b = y;
    n = 0;
    while (in_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
    end
    sb.push_back(model(op, x, y));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid; pops the matching expectation
  task automatic wait_out(output exp_t e, output int cyc, output bit rdy_seen);
    cyc = 0; rdy_seen = 1'b0;
    while (out_valid !== 1'b1 && cyc < 200) begin
      if (in_ready !== 1'b0) rdy_seen = 1'b1;
      @(negedge clk); cyc++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL out_timeout: out_valid=%b required 1", out_valid);
    end
    if (sb.size() > 0) e = sb.pop_front();
    else e = '{res: '0, zero: 1'b1, ovf: 1'b0, ill: 1'b0};
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; alu_control = '0; out_ready = 1'b1;
`ifdef ALU_MC_STICKY_OVF_EN
    ovf_clr = 1'b0;
`endif
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0 || zero !== 1'b1 ||
        overflow !== 1'b0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b vld=%b res=%h z=%b ovf=%b ill=%b required 1 0 0 1 0 0",
               in_ready, out_valid, result, zero, overflow, illegal);
    end
`ifdef ALU_MC_STICKY_OVF_EN
    checks++;
    if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL reset_sticky: got %b required 0", ovf_sticky); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_add();
    exp_t e; int cyc; bit rs;
    send(3'b000, 32'h7FFF_FFFF, 32'h0000_0001);
    wait_out(e, cyc, rs);
    checks++;
    if (result !== 32'h8000_0000 || overflow !== 1'b1 || zero !== 1'b0 || cyc != 0) begin
      errors++;
      $display("FAIL add_ovf: res=%h ovf=%b z=%b lat=%0d required 80000000 1 0 0", result, overflow, zero, cyc);
    end
    checks++;
    if (result !== e.res || overflow !== e.ovf || zero !== e.zero || illegal !== e.ill) begin
      errors++; $display("FAIL add_model: res=%h required %h", result, e.res);
    end
`ifdef ALU_MC_STICKY_OVF_EN
    @(negedge clk);
    checks++;
    if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL sticky_set: got %b required 1", ovf_sticky); end
`endif
  endtask

  task automatic test_sub_slt();
    exp_t e; int cyc; bit rs;
    send(3'b001, 32'h0000_8000, 32'h0000_8000);
    wait_out(e, cyc, rs);
    checks++;
    if (result !== 32'h0 || zero !== 1'b1 || overflow !== 1'b0 || result !== e.res) begin
      errors++; $display("FAIL sub_zero: res=%h z=%b ovf=%b required 0 1 0", result, zero, overflow);
    end
    send(3'b101, -32'sd50, 32'sd5);
    wait_out(e, cyc, rs);
    checks++;
    if (result !== 32'd1 || overflow !== 1'b0 || result !== e.res) begin
      errors++; $display("FAIL slt_neg: res=%h required 1", result);
    end
    send(3'b101, 32'sd5, -32'sd50);
    wait_out(e, cyc, rs);
    checks++;
    if (result !== 32'd0 || zero !== 1'b1 || result !== e.res) begin
      errors++; $display("FAIL slt_pos: res=%h z=%b required 0 1", result, zero);
    end
`ifdef ALU_MC_STICKY_OVF_EN
    checks++;
    if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL sticky_hold: got %b required 1", ovf_sticky); end
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    checks++;
    if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL sticky_clr: got %b required 0", ovf_sticky); end
`endif
  endtask

  task automatic test_mul();
    exp_t e; int cyc; bit rs;
    send(3'b100, 32'h0000_1234, 32'h0000_4321);
    wait_out(e, cyc, rs);
    checks++;
    if (result !== 32'h04C5_F4B4 || overflow !== 1'b0 || zero !== 1'b0 || cyc != 32 || rs) begin
      errors++;
      $display("FAIL mul_small: res=%h ovf=%b lat=%0d rdy_seen=%b required 04c5f4b4 0 32 0",
               result, overflow, cyc, rs);
    end
    send(3'b100, 32'h0001_0000, 32'h0001_0000);
    wait_out(e, cyc, rs);
    checks++;
    if (result !== 32'h0 || zero !== 1'b1 || overflow !== 1'b1 || result !== e.res) begin
      errors++; $display("FAIL mul_ovf: res=%h z=%b ovf=%b required 0 1 1", result, zero, overflow);
    end
    send(3'b100, 32'hDEAD_BEEF, 32'h0000_0FFF);
    wait_out(e, cyc, rs);
    checks++;
    if (result !== e.res || overflow !== e.ovf || zero !== e.zero) begin
      errors++; $display("FAIL mul_model: res=%h ovf=%b required %h %b", result, overflow, e.res, e.ovf);
    end
  endtask

  task automatic test_backpressure();
    exp_t e; int cyc; bit rs; bit bad;
    @(negedge clk); out_ready = 1'b0;
    send(3'b010, 32'h0000_AAAA, 32'h0000_CCCC);
    wait_out(e, cyc, rs);
    // Competing request while the result is stalled
    in_valid = 1'b1; alu_control = 3'b110; a = 32'h0000_F0F0; b = 32'h0000_0FF0;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (result !== 32'h0000_8888 || out_valid !== 1'b1 || in_ready !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad || e.res !== 32'h0000_8888) begin
      errors++; $display("FAIL bp_hold: res=%h vld=%b rdy=%b required 00008888 1 0", result, out_valid, in_ready);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: vld=%b rdy=%b required 0 1", out_valid, in_ready);
    end
    sb.push_back(model(3'b110, 32'h0000_F0F0, 32'h0000_0FF0));
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(e, cyc, rs);
    checks++;
    if (result !== 32'h0000_FF00 || result !== e.res || cyc != 0) begin
      errors++; $display("FAIL bp_next: res=%h lat=%0d required 0000ff00 0", result, cyc);
    end
  endtask

  task automatic test_reset_mid_mul();
    exp_t e; int cyc; bit rs;
    send(3'b100, 32'h0000_FFFF, 32'h0000_FFFF);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0 || zero !== 1'b1 ||
        overflow !== 1'b0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_mul: rdy=%b vld=%b res=%h z=%b ovf=%b ill=%b required 1 0 0 1 0 0",
               in_ready, out_valid, result, zero, overflow, illegal);
    end
    sb.delete();
    @(negedge clk); rst = 1'b0;
    send(3'b000, 32'd2, 32'd3);
    wait_out(e, cyc, rs);
    checks++;
    if (result !== 32'd5 || overflow !== 1'b0 || zero !== 1'b0) begin
      errors++; $display("FAIL rst_then_add: res=%h required 5", result);
    end
  endtask

  task automatic test_illegal();
    exp_t e; int cyc; bit rs;
    send(3'b111, 32'h1234_5678, 32'h9ABC_DEF0);
    wait_out(e, cyc, rs);
    checks++;
    if (illegal !== 1'b1 || result !== '0 || zero !== 1'b1 || overflow !== 1'b0 || e.ill !== 1'b1) begin
      errors++; $display("FAIL illegal_op: ill=%b res=%h z=%b required 1 0 1", illegal, result, zero);
    end
    send(3'b011, 32'h0000_1130, 32'h0000_0204);
    wait_out(e, cyc, rs);
    checks++;
    if (result !== 32'h0000_1334 || illegal !== 1'b0 || result !== e.res) begin
      errors++; $display("FAIL or_after_ill: res=%h ill=%b required 00001334 0", result, illegal);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e; int cyc; bit rs;
    logic [2:0] ops [6];
    ops = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101, 3'b110};
    for (int i = 0; i < 12; i++) begin
      send(ops[i % 6], $urandom, $urandom);
      wait_out(e, cyc, rs);
      checks++;
      if (result !== e.res || zero !== e.zero || overflow !== e.ovf || illegal !== e.ill || cyc != 0) begin
        errors++;
        $display("FAIL b2b_%0d: res=%h z=%b ovf=%b ill=%b required %h %b %b %b", i,
                 result, zero, overflow, illegal, e.res, e.zero, e.ovf, e.ill);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_slt();
    test_mul();
    test_backpressure();
    test_reset_mid_mul();
    test_illegal();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
